// File: rtl/pattern_producer.sv
// pattern_producer: burst-organised stream source with a valid/ready handshake.
// The data word comes from a generator register g: counter, Galois LFSR,
// walking one or constant. Bursts are BURST_LEN beats long, separated by
// GAP_CYCLES idle cycles.
// Optional feature macro: PATTERN_PRODUCER_LFSR_EN builds the LFSR for mode 1.
// Without it, mode 1 behaves as the counter and LFSR_TAPS is ignored.
module pattern_producer #(
  parameter int unsigned            DATA_WIDTH  = 8,
  parameter logic [DATA_WIDTH-1:0]  START_VALUE = '0,
  parameter logic [DATA_WIDTH-1:0]  STEP        = 1,
  parameter logic [DATA_WIDTH-1:0]  LFSR_TAPS   = 'hB8,
  parameter int unsigned            BURST_LEN   = 16,
  parameter int unsigned            GAP_CYCLES  = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i_Enable,
  input  logic [1:0]            i_Mode,
  input  logic                  i_Ready,
  output logic [DATA_WIDTH-1:0] o_Output_Data,
  output logic                  o_Data_Valid,
  output logic                  o_Last,
  output logic [15:0]           o_Burst_Count
);

  localparam int unsigned CNT_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam int unsigned GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(BURST_LEN - 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SEND,
    S_GAP
  } state_t;

  state_t                  state_q;
  state_t                  state_d;
  logic [DATA_WIDTH-1:0]   g_q;
  logic [DATA_WIDTH-1:0]   g_step;
  logic [1:0]              mode_q;
  logic [CNT_W-1:0]        beat_q;
  logic [GAP_W-1:0]        gap_q;
  logic [15:0]             burst_q;
  logic                    sending;
  logic                    xfer;
  logic                    last_xfer;
  logic                    gap_done;
  logic                    start_burst;

  // Next generator value for the pattern latched for the current burst
  function automatic logic [DATA_WIDTH-1:0] advance(input logic [DATA_WIDTH-1:0] v,
                                                    input logic [1:0] m);
    logic [DATA_WIDTH-1:0] r;
    case (m)
`ifdef PATTERN_PRODUCER_LFSR_EN
      2'd1:    r = (v >> 1) ^ (v[0] ? LFSR_TAPS : '0);
`else
      2'd1:    r = v + STEP;
`endif
      2'd2:    r = {v[DATA_WIDTH-2:0], v[DATA_WIDTH-1]};
      2'd3:    r = v;
      default: r = v + STEP;
    endcase
    return r;
  endfunction

  // Zero is the LFSR lock-up state and a walking one needs a set bit
  function automatic logic [DATA_WIDTH-1:0] seed(input logic [DATA_WIDTH-1:0] v,
                                                 input logic [1:0] m);
    logic needs_bit;
`ifdef PATTERN_PRODUCER_LFSR_EN
    needs_bit = (m == 2'd2) || (m == 2'd1);
`else
    needs_bit = (m == 2'd2);
`endif
    return (needs_bit && (v == '0)) ? DATA_WIDTH'(1) : v;
  endfunction

  // Handshake and burst-boundary conditions
  always_comb begin
    sending   = (state_q == S_SEND);
    xfer      = sending & i_Ready;
    last_xfer = xfer & (beat_q == LAST_IDX);
    gap_done  = (state_q == S_GAP) && (gap_q == GAP_LAST);
    g_step    = xfer ? advance(g_q, mode_q) : g_q;
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic; start_burst marks every edge that enters SEND
  always_comb begin
    state_d     = state_q;
    start_burst = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (i_Enable) begin
          state_d     = S_SEND;
          start_burst = 1'b1;
        end
      end
      S_SEND: begin
        if (last_xfer) begin
          if (GAP_CYCLES > 0) begin
            state_d = S_GAP;
          end else if (i_Enable) begin
            state_d     = S_SEND;
            start_burst = 1'b1;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      S_GAP: begin
        if (gap_done) begin
          if (i_Enable) begin
            state_d     = S_SEND;
            start_burst = 1'b1;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Generator, mode latch, beat/gap counters and burst counter
  always_ff @(posedge clk) begin
    if (reset) begin
      g_q     <= START_VALUE;
      mode_q  <= '0;
      beat_q  <= '0;
      gap_q   <= '0;
      burst_q <= '0;
    end else begin
      // On a back-to-back burst the old mode advances g, then the new mode seeds it
      if (start_burst) begin
        mode_q <= i_Mode;
        g_q    <= seed(g_step, i_Mode);
      end else begin
        g_q    <= g_step;
      end
      if (xfer) beat_q <= (beat_q == LAST_IDX) ? '0 : beat_q + 1'b1;
      if (state_q == S_GAP) gap_q <= gap_q + 1'b1;
      else                  gap_q <= '0;
      if (last_xfer) burst_q <= burst_q + 16'd1;
    end
  end

  // Outputs decoded from registered state
  always_comb begin
    o_Data_Valid  = sending;
    o_Last        = sending & (beat_q == LAST_IDX);
    o_Output_Data = sending ? g_q : '0;
    o_Burst_Count = burst_q;
  end

endmodule

// File: tb/tb_pattern_producer.sv
// Scoreboard bench for pattern_producer: a reference model predicts each
// burst's beats into a queue, a negedge monitor compares every presented beat.
// A second instance checks burst/gap timing with BURST_LEN=4, GAP_CYCLES=3.
module tb_pattern_producer;

  localparam int unsigned BL = 16;
`ifdef PATTERN_PRODUCER_LFSR_EN
  localparam bit LFSR_ON = 1'b1;
`else
  localparam bit LFSR_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        en_a = 1'b0;
  logic        ready_a = 1'b1;
  logic [1:0]  mode_a = 2'd0;
  logic [7:0]  data_a;
  logic        valid_a, last_a;
  logic [15:0] bc_a;

  logic        en_b = 1'b0;
  logic [7:0]  data_b;
  logic        valid_b, last_b;
  logic [15:0] bc_b;

  pattern_producer u_dut_a (
    .clk(clk), .reset(reset), .i_Enable(en_a), .i_Mode(mode_a), .i_Ready(ready_a),
    .o_Output_Data(data_a), .o_Data_Valid(valid_a), .o_Last(last_a), .o_Burst_Count(bc_a)
  );

  pattern_producer #(.BURST_LEN(4), .GAP_CYCLES(3)) u_dut_b (
    .clk(clk), .reset(reset), .i_Enable(en_b), .i_Mode(2'd0), .i_Ready(1'b1),
    .o_Output_Data(data_b), .o_Data_Valid(valid_b), .o_Last(last_b), .o_Burst_Count(bc_b)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    logic [7:0] d;
    logic       l;
  } beat_t;

  beat_t       sbq[$];
  logic [7:0]  mg = 8'h00;
  int unsigned m_bursts = 0;
  int unsigned m_xfers = 0;
  logic [1:0]  phase_mode = 2'd0;
  bit          rand_ready = 1'b0;
  int          stall_n = 0;

  function automatic logic [7:0] nxt(input logic [7:0] g, input logic [1:0] m);
    int unsigned v;
    v = g;
    case (m)
      2'd1: v = LFSR_ON ? ((v / 2) ^ (((v % 2) == 1) ? 32'hB8 : 32'h0)) : (v + 1) % 256;
      2'd2: v = ((v * 2) % 256) + (v / 128);
      2'd3: v = v;
      default: v = (v + 1) % 256;
    endcase
    return v[7:0];
  endfunction

  task automatic gen_burst(input logic [1:0] m);
    if (((m == 2'd2) || (LFSR_ON && m == 2'd1)) && mg == 8'h00) mg = 8'h01;
    for (int k = 0; k < int'(BL); k++) begin
      sbq.push_back('{d: mg, l: (k == int'(BL) - 1)});
      mg = nxt(mg, m);
    end
  endtask

  // ---------------- input driver ----------------
  // Mid-burst, i_Mode is scrambled; it carries the phase mode whenever a burst can start.
  always @(posedge clk) begin
    #2;
    if (stall_n > 0) begin
      ready_a = 1'b0;
      stall_n--;
    end else begin
      ready_a = rand_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
    end
    mode_a = (valid_a && !last_a) ? 2'($urandom) : phase_mode;
  end

  // ---------------- monitor ----------------
  logic prev_reset = 1'b1, prev_valid = 1'b0, prev_en = 1'b0;
  logic prev_lastx = 1'b0, prev_stall = 1'b0;

  always @(negedge clk) begin
    if (prev_reset) begin
      chk("reset_valid", 32'(valid_a), 32'd0);
      chk("reset_last",  32'(last_a),  32'd0);
      chk("reset_data",  32'(data_a),  32'd0);
      chk("reset_count", 32'(bc_a),    32'd0);
    end
    if (reset) begin
      sbq.delete();
      mg       = 8'h00;
      m_bursts = 0;
    end else begin
      if (!prev_reset && (!prev_valid || prev_lastx))
        chk("valid_follows_enable", 32'(valid_a), 32'(prev_en));
      if (!prev_reset && prev_stall)
        chk("stall_valid_held", 32'(valid_a), 32'd1);
      if (valid_a) begin
        if (sbq.size() == 0) gen_burst(phase_mode);
        chk("beat_data", 32'(data_a), 32'(sbq[0].d));
        chk("beat_last", 32'(last_a), 32'(sbq[0].l));
        if (ready_a) begin
          chk("burst_count", 32'(bc_a), 32'(m_bursts[15:0]));
          if (sbq[0].l) m_bursts++;
          void'(sbq.pop_front());
          m_xfers++;
        end
      end else begin
        chk("idle_last_low", 32'(last_a), 32'd0);
      end
    end
    prev_reset = reset;
    prev_valid = valid_a;
    prev_en    = en_a;
    prev_lastx = valid_a & ready_a & last_a & ~reset;
    prev_stall = valid_a & ~ready_a & ~reset;
  end

  // ---------------- sequencing ----------------
  task automatic step();
    @(posedge clk);
    #3;
  endtask

  task automatic wait_presented(input int unsigned qsize, input string name);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (valid_a && sbq.size() == qsize) begin
        ok = 1'b1;
        break;
      end
      step();
    end
    chk(name, 32'(ok), 32'd1);
  endtask

  task automatic drain(input string name);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 600; i++) begin
      step();
      if (sbq.size() == 0 && !valid_a) begin
        ok = 1'b1;
        break;
      end
    end
    chk(name, 32'(ok), 32'd1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    bit          found;
    int unsigned k;
    repeat (3) step();
    reset = 1'b0;
    step();

    // Burst/gap timing on the second instance: 4 valid beats, 3 idle cycles
    en_b  = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (valid_b) begin
        found = 1'b1;
        break;
      end
    end
    chk("gap_dut_start", 32'(found), 32'd1);
    k = 0;
    for (int i = 0; i < 28; i++) begin
      chk("gap_valid", 32'(valid_b), ((i % 7) < 4) ? 32'd1 : 32'd0);
      if (valid_b) begin
        chk("gap_data", 32'(data_b), 32'(k % 256));
        chk("gap_last", 32'(last_b), ((i % 7) == 3) ? 32'd1 : 32'd0);
        k++;
      end
      step();
    end
    en_b = 1'b0;

    // Counter bursts back to back with a 3-cycle stall on beat 5 of the first burst
    phase_mode = 2'd0;
    step();
    en_a = 1'b1;
    wait_presented(BL - 4, "reach_beat4");
    stall_n = 3;
    found = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (m_xfers == 32) begin
        found = 1'b1;
        break;
      end
      step();
    end
    chk("reach_32_beats", 32'(found), 32'd1);
    chk("burst_count_after_32", 32'(bc_a), 32'd2);

    // Enable dropped at beat 2: burst must complete, then stay idle
    wait_presented(BL - 2, "reach_beat2");
    en_a = 1'b0;
    drain("drain_after_enable_drop");
    repeat (10) step();

    // Randomized phases: random mode, random backpressure
    for (int p = 0; p < 6; p++) begin
      phase_mode = 2'($urandom);
      rand_ready = 1'b1;
      step();
      en_a = 1'b1;
      repeat ($urandom_range(20, 80)) step();
      en_a = 1'b0;
      drain("drain_random_phase");
      rand_ready = 1'b0;
    end

    // Reset mid-burst at beat 7, then restart in mode 1 from START_VALUE
    phase_mode = 2'd0;
    step();
    en_a = 1'b1;
    wait_presented(BL - 7, "reach_beat7");
    reset = 1'b1;
    en_a  = 1'b0;
    step();
    reset = 1'b0;
    phase_mode = 2'd1;
    repeat (2) step();
    en_a = 1'b1;
    repeat (40) step();
    en_a = 1'b0;
    drain("drain_after_reset");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
